decode_hazard_scheduler: RTL and testbench

DECODE_HAZARD_SCHEDULER -- requirements
Module: decode_hazard_scheduler

---
 rtl/udlx_ctrl_pkg.sv | 17 +
 rtl/decode_hazard_scheduler_if.sv | 43 ++++
 rtl/decode_hazard_scheduler_scoreboard.sv | 47 ++++
 rtl/decode_hazard_scheduler.sv | 104 ++++++++++
 tb/tb_decode_hazard_scheduler.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/udlx_ctrl_pkg.sv
// Shared decode-control definitions: flush FSM encoding and scheduler defaults.
package udlx_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } sched_state_t;

  localparam int FLUSH_CYCLES_DEFAULT   = 2;
  localparam int REG_ADDR_WIDTH_DEFAULT = 5;

  // Counter must hold FLUSH_CYCLES itself, hence the +1.
  function automatic int flush_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/decode_hazard_scheduler_if.sv
// ID-stage hazard/flush control bundle; master = pipeline side, slave = scheduler.
interface decode_hazard_scheduler_if
  import udlx_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  logic                      if_id_rd_reg_a_en;
  logic                      if_id_rd_reg_b_en;
  logic [REG_ADDR_WIDTH-1:0] if_id_rd_reg_a_addr;
  logic [REG_ADDR_WIDTH-1:0] if_id_rd_reg_b_addr;
  logic                      id_reg_wr_en;
  logic [REG_ADDR_WIDTH-1:0] id_reg_wr_addr;
  logic                      id_mem_data_rd_en;
  logic                      wb_write_enable;
  logic [REG_ADDR_WIDTH-1:0] wb_reg_wr_addr;
  logic                      select_new_pc;

  logic                      inst_rd_en;
  logic                      stall;
  logic                      general_flush;
  logic                      decode_flush;
  logic [NUM_REGS-1:0]       pending_mask;

  modport master (
    output if_id_rd_reg_a_en, if_id_rd_reg_b_en,
    output if_id_rd_reg_a_addr, if_id_rd_reg_b_addr,
    output id_reg_wr_en, id_reg_wr_addr, id_mem_data_rd_en,
    output wb_write_enable, wb_reg_wr_addr, select_new_pc,
    input  inst_rd_en, stall, general_flush, decode_flush, pending_mask
  );

  modport slave (
    input  if_id_rd_reg_a_en, if_id_rd_reg_b_en,
    input  if_id_rd_reg_a_addr, if_id_rd_reg_b_addr,
    input  id_reg_wr_en, id_reg_wr_addr, id_mem_data_rd_en,
    input  wb_write_enable, wb_reg_wr_addr, select_new_pc,
    output inst_rd_en, stall, general_flush, decode_flush, pending_mask
  );

endinterface

// File: rtl/decode_hazard_scheduler_scoreboard.sv
// One pending bit per register for in-flight loads; set wins over clear, r0 never set.
// Lookups are combinational and see a same-cycle write-back clear as already retired.
module reg_scoreboard
  import udlx_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT,
  localparam int NUM_REGS      = 1 << REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      set_en,
  input  logic [REG_ADDR_WIDTH-1:0] set_addr,
  input  logic                      clr_en,
  input  logic [REG_ADDR_WIDTH-1:0] clr_addr,
  input  logic                      lkp_a_en,
  input  logic [REG_ADDR_WIDTH-1:0] lkp_a_addr,
  input  logic                      lkp_b_en,
  input  logic [REG_ADDR_WIDTH-1:0] lkp_b_addr,
  output logic                      lkp_a_hit,
  output logic                      lkp_b_hit,
  output logic [NUM_REGS-1:0]       pending
);

  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && (set_addr != '0)) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  assign lkp_a_hit = lkp_a_en && (lkp_a_addr != '0) &&
                     pending[lkp_a_addr] && !clr_mask[lkp_a_addr];
  assign lkp_b_hit = lkp_b_en && (lkp_b_addr != '0) &&
                     pending[lkp_b_addr] && !clr_mask[lkp_b_addr];

endmodule

// File: rtl/decode_hazard_scheduler.sv
// Load-use stall and branch flush control for ID; stall/decode_flush combinational, FSM 1-cycle.
// Optional HAZARD_SCHED_STALL_COUNT_EN adds a saturating 16-bit stall cycle counter.
module decode_hazard_scheduler
  import udlx_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT,
  parameter int FLUSH_CYCLES   = FLUSH_CYCLES_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  decode_hazard_scheduler_if.slave  bus
`ifdef HAZARD_SCHED_STALL_COUNT_EN
  ,
  output logic [15:0]               stall_count
`endif
);

  localparam int CNT_W = flush_cnt_width(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sched_state_t     state;
  logic [CNT_W-1:0] flush_cnt;
  logic             in_run;
  logic             hit_a;
  logic             hit_b;
  logic             stall_int;
  logic             sb_set_en;

  assign in_run    = (state == ST_RUN);
  assign stall_int = in_run && (hit_a || hit_b);
  // Loads decoded while flushing are being squashed, so they never reserve a register.
  assign sb_set_en = in_run && !stall_int && bus.id_mem_data_rd_en && bus.id_reg_wr_en;

  reg_scoreboard #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (sb_set_en),
    .set_addr   (bus.id_reg_wr_addr),
    .clr_en     (bus.wb_write_enable),
    .clr_addr   (bus.wb_reg_wr_addr),
    .lkp_a_en   (bus.if_id_rd_reg_a_en),
    .lkp_a_addr (bus.if_id_rd_reg_a_addr),
    .lkp_b_en   (bus.if_id_rd_reg_b_en),
    .lkp_b_addr (bus.if_id_rd_reg_b_addr),
    .lkp_a_hit  (hit_a),
    .lkp_b_hit  (hit_b),
    .pending    (bus.pending_mask)
  );

  // A new redirect while flushing restarts the full flush window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.select_new_pc) begin
            state     <= ST_FLUSH;
            flush_cnt <= CNT_LOAD;
          end
        end
        ST_FLUSH: begin
          if (bus.select_new_pc) begin
            flush_cnt <= CNT_LOAD;
          end else if (flush_cnt == CNT_ONE) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt - CNT_ONE;
          end
        end
        default: begin
          state     <= ST_RUN;
          flush_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.stall         = stall_int;
  assign bus.inst_rd_en    = !stall_int;
  assign bus.general_flush = (state == ST_FLUSH);
  // Gate the redirect term so decode_flush stays low while reset is held.
  assign bus.decode_flush  = (state == ST_FLUSH) || (rst_n && bus.select_new_pc);

`ifdef HAZARD_SCHED_STALL_COUNT_EN
  logic [15:0] stall_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else if (stall_int && (stall_count_q != 16'hFFFF)) begin
      stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_decode_hazard_scheduler.sv
// Directed bench for decode_hazard_scheduler: load-use stalls, r0, set/clear priority, flush, reset.
module tb_decode_hazard_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decode_hazard_scheduler_if #(.REG_ADDR_WIDTH(5)) bus ();

`ifdef HAZARD_SCHED_STALL_COUNT_EN
  logic [15:0] stall_count;
`endif

  decode_hazard_scheduler #(
    .REG_ADDR_WIDTH (5),
    .FLUSH_CYCLES   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef HAZARD_SCHED_STALL_COUNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.if_id_rd_reg_a_en   = 1'b0;
    bus.if_id_rd_reg_b_en   = 1'b0;
    bus.if_id_rd_reg_a_addr = '0;
    bus.if_id_rd_reg_b_addr = '0;
    bus.id_reg_wr_en        = 1'b0;
    bus.id_reg_wr_addr      = '0;
    bus.id_mem_data_rd_en   = 1'b0;
    bus.wb_write_enable     = 1'b0;
    bus.wb_reg_wr_addr      = '0;
    bus.select_new_pc       = 1'b0;
  endtask

  task automatic load(input logic [4:0] rd);
    bus.id_mem_data_rd_en = 1'b1;
    bus.id_reg_wr_en      = 1'b1;
    bus.id_reg_wr_addr    = rd;
  endtask

  task automatic wb(input logic [4:0] rd);
    bus.wb_write_enable = 1'b1;
    bus.wb_reg_wr_addr  = rd;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle();
    bus.select_new_pc = 1'b1;
    #12;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", bus.stall); end
    checks++; if (bus.inst_rd_en !== 1'b1) begin errors++; $display("FAIL reset_inst_rd_en got %0b want 1", bus.inst_rd_en); end
    checks++; if (bus.general_flush !== 1'b0) begin errors++; $display("FAIL reset_general_flush got %0b want 0", bus.general_flush); end
    checks++; if (bus.decode_flush !== 1'b0) begin errors++; $display("FAIL reset_decode_flush got %0b want 0", bus.decode_flush); end
    checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL reset_pending got %h want 0", bus.pending_mask); end
    bus.select_new_pc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use;
    tick();
    idle(); load(5'd5); #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_issue_stall got %0b want 0", bus.stall); end
    tick();
    checks++; if (bus.pending_mask !== 32'h0000_0020) begin errors++; $display("FAIL lu_set_r5 got %h want 00000020", bus.pending_mask); end
    // Read r5 while a load to r9 waits behind the stall.
    idle(); bus.if_id_rd_reg_a_en = 1'b1; bus.if_id_rd_reg_a_addr = 5'd5; load(5'd9); #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b want 1", bus.stall); end
    checks++; if (bus.inst_rd_en !== 1'b0) begin errors++; $display("FAIL lu_inst_rd_en got %0b want 0", bus.inst_rd_en); end
    tick();
    checks++; if (bus.pending_mask !== 32'h0000_0020) begin errors++; $display("FAIL lu_no_set_when_stalled got %h want 00000020", bus.pending_mask); end
    wb(5'd5); #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_wb_bypass_stall got %0b want 0", bus.stall); end
    checks++; if (bus.inst_rd_en !== 1'b1) begin errors++; $display("FAIL lu_wb_bypass_inst_rd_en got %0b want 1", bus.inst_rd_en); end
    tick();
    checks++; if (bus.pending_mask !== 32'h0000_0200) begin errors++; $display("FAIL lu_clear5_set9 got %h want 00000200", bus.pending_mask); end
    idle(); bus.if_id_rd_reg_b_en = 1'b1; bus.if_id_rd_reg_b_addr = 5'd9; #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_port_b_stall got %0b want 1", bus.stall); end
    wb(5'd9); #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_port_b_bypass got %0b want 0", bus.stall); end
    tick();
    checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL lu_all_clear got %h want 0", bus.pending_mask); end
    idle();
  endtask

  task automatic test_r0;
    idle(); load(5'd0); #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL r0_issue_stall got %0b want 0", bus.stall); end
    tick();
    checks++; if (bus.pending_mask[0] !== 1'b0) begin errors++; $display("FAIL r0_pending got %0b want 0", bus.pending_mask[0]); end
    idle();
    bus.if_id_rd_reg_a_en = 1'b1; bus.if_id_rd_reg_b_en = 1'b1; #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL r0_read_stall got %0b want 0", bus.stall); end
    tick();
    checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL r0_mask got %h want 0", bus.pending_mask); end
    idle();
  endtask

  task automatic test_set_clear_same;
    idle(); load(5'd7);
    tick();
    checks++; if (bus.pending_mask !== 32'h0000_0080) begin errors++; $display("FAIL sc_set7 got %h want 00000080", bus.pending_mask); end
    load(5'd7); wb(5'd7);
    tick();
    checks++; if (bus.pending_mask !== 32'h0000_0080) begin errors++; $display("FAIL sc_set_wins got %h want 00000080", bus.pending_mask); end
    idle(); load(5'd3); wb(5'd7);
    tick();
    checks++; if (bus.pending_mask !== 32'h0000_0008) begin errors++; $display("FAIL sc_set3_clr7 got %h want 00000008", bus.pending_mask); end
    idle(); wb(5'd3);
    tick();
    checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL sc_clr3 got %h want 0", bus.pending_mask); end
    idle();
  endtask

  task automatic flush_run(input bit second_pulse, output int n);
    bus.select_new_pc = 1'b1; #1;
    checks++; if (bus.decode_flush !== 1'b1) begin errors++; $display("FAIL fl_run_decode_flush got %0b want 1", bus.decode_flush); end
    checks++; if (bus.general_flush !== 1'b0) begin errors++; $display("FAIL fl_run_general_flush got %0b want 0", bus.general_flush); end
    tick();
    n = 0;
    for (int i = 0; i < 12 && bus.general_flush === 1'b1; i++) begin
      n++;
      bus.select_new_pc = second_pulse && (n == 1);
      checks++; if (bus.decode_flush !== 1'b1) begin errors++; $display("FAIL fl_decode_flush cyc %0d got %0b want 1", n, bus.decode_flush); end
      tick();
    end
    bus.select_new_pc = 1'b0;
  endtask

  task automatic test_flush;
    int n;
    idle();
    flush_run(1'b0, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL fl_single_len got %0d want 2", n); end
    #1;
    checks++; if (bus.decode_flush !== 1'b0) begin errors++; $display("FAIL fl_back_to_run got %0b want 0", bus.decode_flush); end
    flush_run(1'b1, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL fl_reload_len got %0d want 3", n); end
    idle();
  endtask

  task automatic test_flush_load_reset;
    idle(); load(5'd6);
    tick();
    idle(); bus.select_new_pc = 1'b1;
    tick();
    bus.select_new_pc = 1'b0; load(5'd4);
    bus.if_id_rd_reg_a_en = 1'b1; bus.if_id_rd_reg_a_addr = 5'd6; #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL fr_flush_stall got %0b want 0", bus.stall); end
    checks++; if (bus.inst_rd_en !== 1'b1) begin errors++; $display("FAIL fr_flush_inst_rd_en got %0b want 1", bus.inst_rd_en); end
    tick();
    checks++; if (bus.pending_mask !== 32'h0000_0040) begin errors++; $display("FAIL fr_no_set_in_flush got %h want 00000040", bus.pending_mask); end
    wb(5'd6);
    tick();
    checks++; if (bus.general_flush !== 1'b0) begin errors++; $display("FAIL fr_flush_end got %0b want 0", bus.general_flush); end
    checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL fr_clear_in_flush got %h want 0", bus.pending_mask); end
    idle(); load(5'd8);
    tick();
    idle(); bus.select_new_pc = 1'b1;
    tick();
    bus.if_id_rd_reg_a_en = 1'b1; bus.if_id_rd_reg_a_addr = 5'd8;
    checks++; if (bus.general_flush !== 1'b1) begin errors++; $display("FAIL fr_pre_reset_flush got %0b want 1", bus.general_flush); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.general_flush !== 1'b0) begin errors++; $display("FAIL fr_arst_general_flush got %0b want 0", bus.general_flush); end
    checks++; if (bus.decode_flush !== 1'b0) begin errors++; $display("FAIL fr_arst_decode_flush got %0b want 0", bus.decode_flush); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL fr_arst_stall got %0b want 0", bus.stall); end
    checks++; if (bus.inst_rd_en !== 1'b1) begin errors++; $display("FAIL fr_arst_inst_rd_en got %0b want 1", bus.inst_rd_en); end
    checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL fr_arst_pending got %h want 0", bus.pending_mask); end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef HAZARD_SCHED_STALL_COUNT_EN
  task automatic test_stall_count;
    tick();
    idle(); load(5'd5);
    tick();
    idle(); bus.if_id_rd_reg_a_en = 1'b1; bus.if_id_rd_reg_a_addr = 5'd5;
    force dut.stall_count_q = 16'hFFFE;
    #1;
    release dut.stall_count_q;
    tick(); tick(); tick();
    checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sc_saturate got %h want ffff", stall_count); end
    wb(5'd5);
    tick();
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_r0();
    test_set_clear_same();
    test_flush();
    test_flush_load_reset();
`ifdef HAZARD_SCHED_STALL_COUNT_EN
    test_stall_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
